// File: rtl/multi_channel_firewall_fsm.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : multi_channel_firewall_fsm
// Description : One independent firewall FSM per channel:
//               NORMAL -> ALERT -> ISOLATE -> RECOVER. Isolation length
//               doubles with each strike, up to a saturation level. The
//               module also reports how many channels are currently blocked.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_channel_firewall_fsm #(
    parameter int NUM_CH         = 4,
    parameter int ALERT_THRESH   = 3,
    parameter int ISOLATE_CYCLES = 20,
    parameter int RECOVER_CYCLES = 8,
    parameter int MAX_STRIKE     = 2,
    parameter int GLOBAL_THRESH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_CH-1:0]     rule_violation,
    input  logic [NUM_CH-1:0]     pattern_violation,
    input  logic [NUM_CH-1:0]     clear_req,
    output logic [NUM_CH-1:0]     ch_alert,
    output logic [NUM_CH-1:0]     ch_block,
    output logic [2*NUM_CH-1:0]   ch_state,
    output logic [NUM_CH-1:0]     isolate_event,
    output logic [4:0]            block_count,
    output logic                  global_block
);

    // Timer and duration must hold the longest escalated isolation.
    localparam int         TW           = $clog2((ISOLATE_CYCLES << MAX_STRIKE) + 1);
    localparam logic [7:0] C_ALERT_LAST = 8'(ALERT_THRESH - 1);
    localparam logic [7:0] C_RECOVER    = 8'(RECOVER_CYCLES);
    localparam logic [1:0] C_MAX_STRIKE = 2'(MAX_STRIKE);

    typedef enum logic [1:0] {
        ST_NORMAL  = 2'b00,
        ST_ALERT   = 2'b01,
        ST_ISOLATE = 2'b10,
        ST_RECOVER = 2'b11
    } state_t;

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        state_t          state_q,     state_d;
        logic [7:0]      alert_cnt_q, alert_cnt_d;
        logic [TW-1:0]   timer_q,     timer_d;
        logic [TW-1:0]   dur_q,       dur_d;
        logic [7:0]      rec_cnt_q,   rec_cnt_d;
        logic [1:0]      strike_q,    strike_d;
        logic            v;
        logic            enter_iso;

        assign v = rule_violation[n] | pattern_violation[n];

        // Per-channel state register with asynchronous clear.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q     <= ST_NORMAL;
                alert_cnt_q <= '0;
                timer_q     <= '0;
                dur_q       <= '0;
                rec_cnt_q   <= '0;
                strike_q    <= '0;
            end else begin
                state_q     <= state_d;
                alert_cnt_q <= alert_cnt_d;
                timer_q     <= timer_d;
                dur_q       <= dur_d;
                rec_cnt_q   <= rec_cnt_d;
                strike_q    <= strike_d;
            end
        end

        // Next-state logic; manual clear overrides every transition.
        always_comb begin
            state_d     = state_q;
            alert_cnt_d = alert_cnt_q;
            timer_d     = timer_q;
            dur_d       = dur_q;
            rec_cnt_d   = rec_cnt_q;
            strike_d    = strike_q;
            enter_iso   = 1'b0;

            if (clear_req[n]) begin
                state_d     = ST_NORMAL;
                alert_cnt_d = '0;
                timer_d     = '0;
                dur_d       = '0;
                rec_cnt_d   = '0;
                strike_d    = '0;
            end else begin
                case (state_q)
                    ST_NORMAL: begin
                        if (v) begin
                            state_d     = ST_ALERT;
                            alert_cnt_d = 8'd1;
                        end else begin
                            alert_cnt_d = '0;
                        end
                    end
                    ST_ALERT: begin
                        if (v) begin
                            if (alert_cnt_q == C_ALERT_LAST) begin
                                enter_iso = 1'b1;
                            end else if (alert_cnt_q != 8'hFF) begin
                                alert_cnt_d = alert_cnt_q + 8'd1;
                            end
                        end else begin
                            state_d     = ST_NORMAL;
                            alert_cnt_d = '0;
                        end
                    end
                    ST_ISOLATE: begin
                        // Violations are ignored until the full duration elapses.
                        if (timer_q + TW'(1) == dur_q) begin
                            state_d   = ST_RECOVER;
                            rec_cnt_d = '0;
                        end else begin
                            timer_d = timer_q + TW'(1);
                        end
                    end
                    ST_RECOVER: begin
                        if (v) begin
                            enter_iso = 1'b1;
                            rec_cnt_d = '0;
                        end else if (rec_cnt_q + 8'd1 == C_RECOVER) begin
                            state_d   = ST_NORMAL;
                            rec_cnt_d = '0;
                        end else begin
                            rec_cnt_d = rec_cnt_q + 8'd1;
                        end
                    end
                    default: begin
                        state_d = ST_NORMAL;
                    end
                endcase

                // Duration uses the strike level before it is bumped.
                if (enter_iso) begin
                    state_d     = ST_ISOLATE;
                    alert_cnt_d = '0;
                    timer_d     = '0;
                    dur_d       = TW'(ISOLATE_CYCLES) << strike_q;
                    strike_d    = (strike_q < C_MAX_STRIKE) ? strike_q + 2'd1 : strike_q;
                end
            end
        end

        assign ch_state[2*n +: 2] = state_q;
        assign ch_alert[n]        = (state_q == ST_ALERT);
        assign ch_block[n]        = (state_q == ST_ISOLATE);
        assign isolate_event[n]   = (state_q == ST_ISOLATE) && (timer_q == '0);
    end

    // Population count of isolated channels and the global block flag.
    always_comb begin
        block_count = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            block_count = block_count + {4'd0, ch_block[i]};
        end
        global_block = (block_count >= 5'(GLOBAL_THRESH));
    end

endmodule
`default_nettype wire
